rfblackwidow_dcache_wrctl: RTL

Parametrised data-cache write controller for the BlackWidow memory pipeline. It merges two write sources into the single data-RAM write port: line-fill beats from the bus interface, and store hits buffered in a small in-order store queue. It enforces write permission, holds stores that target a line currently being filled, and invalidates a way when a fill aborts on error.

---
 rtl/rfblackwidow_dcache_wrctl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rfblackwidow_dcache_wrctl.sv
// rtl/rfblackwidow_dcache_wrctl.sv - data-cache write controller: fill beats plus in-order store queue
// Merges line-fill beats and buffered store hits onto one data-RAM write port.
module rfblackwidow_dcache_wrctl #(
    parameter int WAYS     = 4,
    parameter int ADR_W    = 32,
    parameter int DATA_W   = 128,
    parameter int LINE_W   = 512,
    parameter int SQ_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_st_req,
    input  logic [ADR_W-1:0]    i_st_adr,
    input  logic [DATA_W-1:0]   i_st_dat,
    input  logic [DATA_W/8-1:0] i_st_sel,
    input  logic [WAYS-1:0]     i_st_way,
    input  logic                i_dce,
    input  logic                i_hit,
    input  logic                i_inv,
    input  logic                i_acr_w,
    output logic                o_st_rdy,
    output logic                o_perm_err,
    input  logic                i_fill_start,
    input  logic [ADR_W-1:0]    i_fill_adr,
    input  logic [WAYS-1:0]     i_fill_way,
    input  logic                i_fill_vld,
    input  logic [DATA_W-1:0]   i_fill_dat,
    input  logic                i_fill_err,
    output logic                o_busy,
    output logic                o_inv_line,
    output logic [WAYS-1:0]     o_inv_way,
    output logic [ADR_W-1:0]    o_inv_adr,
    output logic                o_wr,
    output logic [WAYS-1:0]     o_wr_way,
    output logic [ADR_W-1:0]    o_wr_adr,
    output logic [DATA_W-1:0]   o_wr_dat,
    output logic [DATA_W/8-1:0] o_wr_sel
);

    localparam int FILL_BEATS = LINE_W / DATA_W;
    localparam int SEL_W      = DATA_W / 8;
    localparam int BOFF_W     = $clog2(DATA_W / 8);
    localparam int BEAT_W     = $clog2(FILL_BEATS);
    localparam int PTR_W      = $clog2(SQ_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam logic [ADR_W-1:0] LINE_MASK = ~(ADR_W'(LINE_W / 8 - 1));

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t              r_state, w_state_nxt;
    logic [BEAT_W-1:0]   r_beat, w_beat_nxt;
    logic [ADR_W-1:0]    r_line, w_line_nxt;
    logic [WAYS-1:0]     r_fway, w_fway_nxt;
    logic                w_fill_wr, w_fill_abort, w_port_fill;

    logic [ADR_W-1:0]    r_sq_adr [SQ_DEPTH];
    logic [DATA_W-1:0]   r_sq_dat [SQ_DEPTH];
    logic [SEL_W-1:0]    r_sq_sel [SQ_DEPTH];
    logic [WAYS-1:0]     r_sq_way [SQ_DEPTH];
    logic [PTR_W-1:0]    r_wp, r_rp;
    logic [CNT_W-1:0]    r_count;
    logic                w_st_ok, w_push, w_pop, w_head_blk;

    logic                r_wr, r_perm_err, r_inv_line;
    logic [WAYS-1:0]     r_wr_way, r_inv_way;
    logic [ADR_W-1:0]    r_wr_adr, r_inv_adr;
    logic [DATA_W-1:0]   r_wr_dat;
    logic [SEL_W-1:0]    r_wr_sel;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_line  <= '0;
            r_fway  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_line  <= w_line_nxt;
            r_fway  <= w_fway_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_beat_nxt   = r_beat;
        w_line_nxt   = r_line;
        w_fway_nxt   = r_fway;
        w_fill_wr    = 1'b0;
        w_fill_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_fill_start) begin
                    w_state_nxt = S_FILL;
                    w_line_nxt  = i_fill_adr & LINE_MASK;
                    w_fway_nxt  = i_fill_way;
                    w_beat_nxt  = '0;
                end
            end
            S_FILL: begin
                if (i_fill_vld) begin
                    if (i_fill_err) begin
                        w_fill_abort = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_fill_wr  = 1'b1;
                        w_beat_nxt = r_beat + 1'b1;
                        if (r_beat == BEAT_W'(FILL_BEATS - 1))
                            w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Any valid beat during a fill owns the port, including an error beat.
    assign w_port_fill = (r_state == S_FILL) && i_fill_vld;
    assign w_head_blk  = (r_state == S_FILL) && ((r_sq_adr[r_rp] & LINE_MASK) == r_line);
    assign w_pop       = (r_count != '0) && !w_port_fill && !w_head_blk;
    assign o_st_rdy    = !i_rst && (r_count != CNT_W'(SQ_DEPTH));
    assign w_st_ok     = i_st_req && i_dce && i_hit && !i_inv && o_st_rdy;
    assign w_push      = w_st_ok && i_acr_w;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_sq_adr[r_wp] <= i_st_adr;
            r_sq_dat[r_wp] <= i_st_dat;
            r_sq_sel[r_wp] <= i_st_sel;
            r_sq_way[r_wp] <= i_st_way;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr       <= 1'b0;
            r_wr_way   <= '0;
            r_wr_adr   <= '0;
            r_wr_dat   <= '0;
            r_wr_sel   <= '0;
            r_perm_err <= 1'b0;
            r_inv_line <= 1'b0;
            r_inv_way  <= '0;
            r_inv_adr  <= '0;
        end else begin
            r_wr       <= w_fill_wr || w_pop;
            r_perm_err <= w_st_ok && !i_acr_w;
            r_inv_line <= w_fill_abort;
            if (w_fill_wr) begin
                r_wr_way <= r_fway;
                r_wr_adr <= r_line + (ADR_W'(r_beat) << BOFF_W);
                r_wr_dat <= i_fill_dat;
                r_wr_sel <= '1;
            end else if (w_pop) begin
                r_wr_way <= r_sq_way[r_rp];
                r_wr_adr <= r_sq_adr[r_rp];
                r_wr_dat <= r_sq_dat[r_rp];
                r_wr_sel <= r_sq_sel[r_rp];
            end
            if (w_fill_abort) begin
                r_inv_way <= r_fway;
                r_inv_adr <= r_line;
            end
        end
    end

    assign o_busy     = (r_state == S_FILL);
    assign o_wr       = r_wr;
    assign o_wr_way   = r_wr_way;
    assign o_wr_adr   = r_wr_adr;
    assign o_wr_dat   = r_wr_dat;
    assign o_wr_sel   = r_wr_sel;
    assign o_perm_err = r_perm_err;
    assign o_inv_line = r_inv_line;
    assign o_inv_way  = r_inv_way;
    assign o_inv_adr  = r_inv_adr;

endmodule
